// File: rtl/rf_wb_arb_pkg.sv
// Shared constants, types and round-robin helpers for the register-file
// write-back arbiter.
package rf_wb_arb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_MDU = 2;

    typedef logic [1:0]         req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    // One-hot pick of the first requester after 'last', wrapping MDU -> ALU.
    function automatic req_vec_t rr_pick(input req_vec_t req, input req_idx_t last);
        req_vec_t gnt;
        req_idx_t idx;
        gnt = '0;
        idx = last;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == req_idx_t'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
            if (req[idx] && (gnt == '0)) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic req_idx_t onehot_idx(input req_vec_t gnt);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dffre.sv
// Enable flop with asynchronous active-low reset to zero.
module dffre #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding slot: valid/ready intake, x0 drop, and clear
// on grant unless refilled on the same edge.
module rf_wb_slot
    import rf_wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_rdy,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic r_vld;
    logic w_fill;

    assign o_rdy  = ~r_vld | i_grant;
    // x0 results complete the handshake but never occupy the slot.
    assign w_fill = i_vld & o_rdy & (i_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else if (w_fill) begin
            r_vld <= 1'b1;
        end else if (i_grant) begin
            r_vld <= 1'b0;
        end
    end

    dffre #(
        .WIDTH(ADDR_W)
    ) u_addr (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (w_fill),
        .i_d  (i_addr),
        .o_q  (o_addr)
    );

    dffre #(
        .WIDTH(DATA_W)
    ) u_data (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (w_fill),
        .i_d  (i_data),
        .o_q  (o_data)
    );

    assign o_vld = r_vld;

endmodule

// File: rtl/rf_wb_arb.sv
// Round-robin write-back arbiter sharing one register-file write port among
// the ALU, LSU and MDU, with a pending-write mask for decode hazard checks.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_alu_wb_vld,
    input  logic [ADDR_W-1:0]   i_alu_wb_addr,
    input  logic [DATA_W-1:0]   i_alu_wb_data,
    output logic                o_alu_wb_rdy,
    input  logic                i_lsu_wb_vld,
    input  logic [ADDR_W-1:0]   i_lsu_wb_addr,
    input  logic [DATA_W-1:0]   i_lsu_wb_data,
    output logic                o_lsu_wb_rdy,
    input  logic                i_mdu_wb_vld,
    input  logic [ADDR_W-1:0]   i_mdu_wb_addr,
    input  logic [DATA_W-1:0]   i_mdu_wb_data,
    output logic                o_mdu_wb_rdy,
    output logic                o_rf_wb_vld,
    output logic [ADDR_W-1:0]   o_rf_wb_addr,
    output logic [DATA_W-1:0]   o_rf_wb_data,
    output logic [NUM_REGS-1:0] o_wb_pend_mask,
    output logic [NUM_REQ-1:0]  o_wb_grant
);

    req_vec_t          w_in_vld;
    logic [ADDR_W-1:0] w_in_addr   [NUM_REQ];
    logic [DATA_W-1:0] w_in_data   [NUM_REQ];
    req_vec_t          w_rdy;
    req_vec_t          w_slot_vld;
    logic [ADDR_W-1:0] w_slot_addr [NUM_REQ];
    logic [DATA_W-1:0] w_slot_data [NUM_REQ];
    req_vec_t          w_grant;
    req_idx_t          r_last_grant;

    assign w_in_vld           = {i_mdu_wb_vld, i_lsu_wb_vld, i_alu_wb_vld};
    assign w_in_addr[REQ_ALU] = i_alu_wb_addr;
    assign w_in_addr[REQ_LSU] = i_lsu_wb_addr;
    assign w_in_addr[REQ_MDU] = i_mdu_wb_addr;
    assign w_in_data[REQ_ALU] = i_alu_wb_data;
    assign w_in_data[REQ_LSU] = i_lsu_wb_data;
    assign w_in_data[REQ_MDU] = i_mdu_wb_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        rf_wb_slot u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_vld  (w_in_vld[g]),
            .i_addr (w_in_addr[g]),
            .i_data (w_in_data[g]),
            .i_grant(w_grant[g]),
            .o_rdy  (w_rdy[g]),
            .o_vld  (w_slot_vld[g]),
            .o_addr (w_slot_addr[g]),
            .o_data (w_slot_data[g])
        );
    end

    // Grant depends only on registered slot state, keeping vld off the rdy path.
    always_comb begin
        w_grant = rr_pick(w_slot_vld, r_last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= req_idx_t'(REQ_MDU);
        end else if (|w_grant) begin
            r_last_grant <= onehot_idx(w_grant);
        end
    end

    always_comb begin
        o_rf_wb_addr   = '0;
        o_rf_wb_data   = '0;
        o_wb_pend_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                o_rf_wb_addr = o_rf_wb_addr | w_slot_addr[i];
                o_rf_wb_data = o_rf_wb_data | w_slot_data[i];
            end
            if (w_slot_vld[i]) begin
                o_wb_pend_mask[w_slot_addr[i]] = 1'b1;
            end
        end
    end

    assign o_rf_wb_vld  = |w_grant;
    assign o_wb_grant   = w_grant;
    assign o_alu_wb_rdy = w_rdy[REQ_ALU];
    assign o_lsu_wb_rdy = w_rdy[REQ_LSU];
    assign o_mdu_wb_rdy = w_rdy[REQ_MDU];

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb: expected writes are queued when driven and
// matched against every register-file write the DUT issues.
module tb_rf_wb_arb;
    import rf_wb_arb_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                alu_vld, lsu_vld, mdu_vld;
    logic [ADDR_W-1:0]   alu_addr, lsu_addr, mdu_addr;
    logic [DATA_W-1:0]   alu_data, lsu_data, mdu_data;
    logic                alu_rdy, lsu_rdy, mdu_rdy;
    logic                rf_vld;
    logic [ADDR_W-1:0]   rf_addr;
    logic [DATA_W-1:0]   rf_data;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REQ-1:0]  grant;

    int checks = 0;
    int errors = 0;
    int alu_wr = 0;
    int lsu_wr = 0;
    int mdu_wr = 0;
    logic [ADDR_W+DATA_W-1:0] sb [$];

    int a_left, l_left, cyc, hit;
    logic [NUM_REQ-1:0] prev_grant;

    always #5 clk = ~clk;

    rf_wb_arb u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_alu_wb_vld  (alu_vld),
        .i_alu_wb_addr (alu_addr),
        .i_alu_wb_data (alu_data),
        .o_alu_wb_rdy  (alu_rdy),
        .i_lsu_wb_vld  (lsu_vld),
        .i_lsu_wb_addr (lsu_addr),
        .i_lsu_wb_data (lsu_data),
        .o_lsu_wb_rdy  (lsu_rdy),
        .i_mdu_wb_vld  (mdu_vld),
        .i_mdu_wb_addr (mdu_addr),
        .i_mdu_wb_data (mdu_data),
        .o_mdu_wb_rdy  (mdu_rdy),
        .o_rf_wb_vld   (rf_vld),
        .o_rf_wb_addr  (rf_addr),
        .o_rf_wb_data  (rf_data),
        .o_wb_pend_mask(pend),
        .o_wb_grant    (grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_vld = 1'b0; lsu_vld = 1'b0; mdu_vld = 1'b0;
        alu_addr = '0;  lsu_addr = '0;  mdu_addr = '0;
        alu_data = '0;  lsu_data = '0;  mdu_data = '0;
    endtask

    // Every write must match a queued expectation; it is then retired.
    always @(negedge clk) begin
        if (rst_n && rf_vld) begin
            hit = -1;
            foreach (sb[k]) begin
                if (hit < 0 && sb[k] === {rf_addr, rf_data}) hit = k;
            end
            chk("wb_expected", 64'(hit >= 0), 64'd1);
            if (hit >= 0) sb.delete(hit);
            case (grant)
                3'b001:  alu_wr++;
                3'b010:  lsu_wr++;
                3'b100:  mdu_wr++;
                default: chk("grant_onehot", 64'(grant), 64'd1);
            endcase
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 64'({alu_rdy, lsu_rdy, mdu_rdy}), 64'b111);
        chk("rst_rf_vld", 64'(rf_vld), 64'd0);
        chk("rst_addr_data", {27'd0, rf_addr, rf_data}, 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single ALU write.
        alu_vld = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        sb.push_back({5'd5, 32'hDEADBEEF});
        mid();
        chk("single_rdy", 64'(alu_rdy), 64'd1);
        tick();
        idle_inputs();
        mid();
        chk("single_vld", 64'(rf_vld), 64'd1);
        chk("single_addr", 64'(rf_addr), 64'd5);
        chk("single_data", 64'(rf_data), 64'hDEADBEEF);
        chk("single_grant", 64'(grant), 64'b001);
        chk("single_pend", 64'(pend), 64'h20);
        tick();
        mid();
        chk("single_after_vld", 64'(rf_vld), 64'd0);
        chk("single_after_pend", 64'(pend), 64'd0);

        // Fresh reset so the round-robin pointer starts at ALU again.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Three-way contention.
        alu_vld = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_0001;
        lsu_vld = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h2222_0002;
        mdu_vld = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h3333_0003;
        sb.push_back({5'd1, 32'h1111_0001});
        sb.push_back({5'd2, 32'h2222_0002});
        sb.push_back({5'd3, 32'h3333_0003});
        mid();
        chk("cont_rdy_all", 64'({alu_rdy, lsu_rdy, mdu_rdy}), 64'b111);
        tick();
        idle_inputs();
        mid();
        chk("cont_pend", 64'(pend), 64'h0E);
        chk("cont_g0", 64'(grant), 64'b001);
        chk("cont_g0_addr", 64'(rf_addr), 64'd1);
        chk("cont_g0_rdy", 64'({lsu_rdy, mdu_rdy}), 64'b00);
        tick();
        mid();
        chk("cont_g1", 64'(grant), 64'b010);
        chk("cont_g1_addr", 64'(rf_addr), 64'd2);
        chk("cont_g1_rdy", 64'({lsu_rdy, mdu_rdy}), 64'b10);
        tick();
        mid();
        chk("cont_g2", 64'(grant), 64'b100);
        chk("cont_g2_data", 64'(rf_data), 64'h3333_0003);
        chk("cont_g2_rdy", 64'(mdu_rdy), 64'd1);
        tick();
        mid();
        chk("cont_idle", 64'(grant), 64'd0);
        tick();

        // ALU and LSU streaming back-to-back.
        alu_wr = 0; lsu_wr = 0;
        a_left = 5; l_left = 5; cyc = 0; prev_grant = '0;
        while ((a_left > 0 || l_left > 0) && cyc < 40) begin
            alu_vld  = (a_left > 0);
            alu_addr = 5'(10 + 5 - a_left);
            alu_data = 32'hA000_0000 + 32'(a_left);
            lsu_vld  = (l_left > 0);
            lsu_addr = 5'(20 + 5 - l_left);
            lsu_data = 32'hB000_0000 + 32'(l_left);
            mid();
            if (alu_vld && alu_rdy) begin
                sb.push_back({alu_addr, alu_data});
                a_left--;
            end
            if (lsu_vld && lsu_rdy) begin
                sb.push_back({lsu_addr, lsu_data});
                l_left--;
            end
            if (grant != '0 && prev_grant != '0) begin
                chk("fair_alternate", 64'(grant != prev_grant), 64'd1);
            end
            prev_grant = grant;
            tick();
            cyc++;
        end
        idle_inputs();
        chk("fair_all_sent", 64'(a_left + l_left), 64'd0);
        repeat (4) tick();
        mid();
        chk("fair_drained", 64'(sb.size()), 64'd0);
        chk("fair_alu_writes", 64'(alu_wr), 64'd5);
        chk("fair_lsu_writes", 64'(lsu_wr), 64'd5);
        tick();

        // x0 write is accepted but dropped.
        lsu_vld = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h1234;
        mid();
        chk("x0_rdy", 64'(lsu_rdy), 64'd1);
        tick();
        idle_inputs();
        mid();
        chk("x0_no_write", 64'(rf_vld), 64'd0);
        chk("x0_no_pend", 64'(pend), 64'd0);
        chk("x0_rdy_after", 64'(lsu_rdy), 64'd1);
        tick();
        mid();
        chk("x0_no_write2", 64'(rf_vld), 64'd0);
        tick();

        // Asynchronous reset while slots hold r7/r8: these must never be written.
        alu_vld = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777_7777;
        lsu_vld = 1'b1; lsu_addr = 5'd8; lsu_data = 32'h8888_8888;
        mid();
        chk("arst_rdy", 64'({alu_rdy, lsu_rdy}), 64'b11);
        tick();
        idle_inputs();
        chk("arst_pend_before", 64'(pend), 64'h180);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(rf_vld), 64'd0);
        chk("arst_pend", 64'(pend), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_addr_data", {27'd0, rf_addr, rf_data}, 64'd0);
        chk("arst_rdy_all", 64'({alu_rdy, lsu_rdy, mdu_rdy}), 64'b111);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            mid();
            chk("arst_no_write", 64'(rf_vld), 64'd0);
        end
        chk("arst_pend_after", 64'(pend), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-back arbiter sharing the register file's single write port among three producers: ALU, LSU and multiply/divide unit (MDU). Each producer hands results over through a valid/ready handshake into its own one-entry holding slot. A round-robin arbiter drains one slot per cycle onto the register-file write port. The block also exports a pending-write mask that the decode stage uses for hazard stalls.

## Interface
- DATA_W, 32, write-back data width
- ADDR_W, 5, register address width (32 architectural registers)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_wb_vld  in  1  ALU result valid
- alu_wb_addr  in  ADDR_W  ALU destination register
- alu_wb_data  in  DATA_W  ALU result
- alu_wb_rdy  out  1  ALU slot can accept this cycle
- lsu_wb_vld / lsu_wb_addr / lsu_wb_data / lsu_wb_rdy  same as ALU, LSU producer
- mdu_wb_vld / mdu_wb_addr / mdu_wb_data / mdu_wb_rdy  same as ALU, MDU producer
- rf_wb_vld  out  1  register-file write enable
- rf_wb_addr  out  ADDR_W  register-file write address
- rf_wb_data  out  DATA_W  register-file write data
- wb_pend_mask  out  32  bit r set = a held slot will write register r
- wb_grant  out  3  one-hot slot drained this cycle (bit0 ALU, bit1 LSU, bit2 MDU)

## Operation
- **Slot per producer:** slot_vld, slot_addr, slot_data.
- **Accept:** a transfer happens when xxx_wb_vld & xxx_wb_rdy. On that edge the slot loads addr/data and sets slot_vld.
- **Ready:** xxx_wb_rdy = ~slot_vld | grant[slot]. A slot drained and refilled in the same cycle gives full throughput of one result per producer per cycle when uncontended.
- **x0 writes:** a transfer with addr 0 is accepted (rdy behaves normally), but the slot is not filled. It never reaches rf_wb_* and never sets wb_pend_mask.
- **Arbitration:** round-robin among slots with slot_vld. Search starts at the index after last_grant, wrapping 2→0. At most one grant per cycle. last_grant updates only on a cycle with a grant.
- **Write port:** rf_wb_vld = |grant. rf_wb_addr/rf_wb_data are muxed combinationally from the granted slot. When idle they are 0.
- **Draining:** on a granted edge, the granted slot clears unless it is refilled by a simultaneous accept.
- **wb_pend_mask:** OR over valid slots of the one-hot decoded slot_addr. Combinational from slot state, so it excludes same-cycle incoming transfers.
- **Ordering:** no ordering between producers. Issue logic must prevent two in-flight writes to the same register from different producers. Within one producer, order is preserved because there is a single slot.
- **Reset:**
  - all slot_vld = 0 and last_grant = MDU (2), so the first search starts at ALU.
  - Outputs: rf_wb_vld = 0, rf_wb_addr = 0, rf_wb_data = 0, wb_grant = 0, wb_pend_mask = 0, all xxx_wb_rdy = 1.
  - Reset asserted mid-operation discards held results immediately, with no write.

## Timing
- **Latency:** accept at edge E, then rf_wb_vld is high in the cycle after E if uncontended. The register file captures at edge E+1. Minimum producer-to-RF latency is one cycle.
- **Contended slots:** a slot waits at most 2 grant cycles (3 requesters, round-robin fairness).
- **Combinational paths:** rdy depends only on registered slot state and the arbiter, with no path from xxx_wb_vld to xxx_wb_rdy.
- rf_wb_* and wb_pend_mask have no combinational path from any producer input.

## Structure
- **Shared package:** DATA_W/ADDR_W constants, requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_MDU=2), NUM_REQ=3.
- **Sub-module rf_wb_slot:** one-entry holding buffer with vld/rdy, x0 drop and grant-clear. Instantiated three times.
- **Registers:** use the codebase's DFFRE enable-flop cell for slot_addr/slot_data, and a reset flop for slot_vld/last_grant.
- The arbiter and output mux live in the top module.

## Test plan
- **Reset:** hold rst_n low, then release → all rdy = 1, rf_wb_vld = 0, wb_pend_mask = 0.
- **Single producer:** ALU sends addr 5, data 0xDEADBEEF at edge E → cycle after E: rf_wb_vld = 1, addr 5, data 0xDEADBEEF, wb_grant = 3'b001, wb_pend_mask bit5 = 1.
- **Three-way contention:** all three send in one cycle (addrs 1/2/3) → grants ALU, LSU, MDU over three consecutive cycles. LSU/MDU rdy stay low until their own grant cycle.
- **Fairness:** ALU and LSU both stream back-to-back for 10 cycles → grants alternate 001/010, each producer gets 5 writes, no loss.
- **x0 write:** LSU sends addr 0, data 0x1234 → accepted, rf_wb_vld stays 0, wb_pend_mask stays 0.
- **Async reset mid-operation:** rst_n asserted while slots hold addrs 7/8 → outputs clear immediately, without waiting for clk. After release, no write to r7/r8 ever occurs.
